// File: rtl/direction_conditioner.sv
// Debounces four direction buttons and turns press events into a one-hot heading.
// A lock holds the heading steady between ticks; one request can wait in a pending slot.
module direction_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       tick,
  output logic [3:0] direction,
  output logic       dir_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {OPEN, LOCKED} state_t;

  logic [3:0]       raw;
  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       level, level_d;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       press, req, cand, pend, pend_next, dir_next;
  logic             req_vld, cand_vld, pend_vld, pend_vld_next, change_next;
  state_t           state, state_next;

  assign raw = {d, u, r, l};

  // Bit order {down, up, right, left}: the opposite heading swaps each pair.
  function automatic logic legal(input logic [3:0] want, input logic [3:0] cur);
    logic [3:0] opp;
    opp = {cur[2], cur[3], cur[0], cur[1]};
    return (want != 4'b0000) && (want != cur) && (want != opp);
  endfunction

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      level_d <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press   = level & ~level_d;
  assign req_vld = |press;

  always_comb begin
    req = 4'b0000;
    if (press[0])      req = 4'b0001;
    else if (press[1]) req = 4'b0010;
    else if (press[2]) req = 4'b0100;
    else if (press[3]) req = 4'b1000;
  end

  // A request landing with tick overrides whatever was pending.
  assign cand     = req_vld ? req : pend;
  assign cand_vld = req_vld | pend_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= OPEN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      OPEN:   if (req_vld && legal(req, direction)) state_next = LOCKED;
      LOCKED: if (tick && !(cand_vld && legal(cand, direction))) state_next = OPEN;
      default: state_next = OPEN;
    endcase
  end

  always_comb begin
    dir_next      = direction;
    change_next   = 1'b0;
    pend_next     = pend;
    pend_vld_next = pend_vld;
    case (state)
      OPEN: begin
        if (req_vld && legal(req, direction)) begin
          dir_next    = req;
          change_next = 1'b1;
        end
      end
      LOCKED: begin
        if (tick) begin
          pend_next     = 4'b0000;
          pend_vld_next = 1'b0;
          if (cand_vld && legal(cand, direction)) begin
            dir_next    = cand;
            change_next = 1'b1;
          end
        end else if (req_vld) begin
          pend_next     = req;
          pend_vld_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage p2: registered heading, pulse and pending slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      direction  <= 4'b0000;
      dir_change <= 1'b0;
      pend       <= 4'b0000;
      pend_vld   <= 1'b0;
    end else begin
      direction  <= dir_next;
      dir_change <= change_next;
      pend       <= pend_next;
      pend_vld   <= pend_vld_next;
    end
  end

endmodule

// File: tb/tb_direction_conditioner.sv
// Bench for direction_conditioner: directed scenarios then random buttons/ticks,
// every cycle compared against a behavioural model of the heading rules.
module tb_direction_conditioner;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset, l, r, u, d, tick;
  logic [3:0] direction;
  logic       dir_change;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  // model state; button vectors are {d,u,r,l}
  bit [3:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_dir, m_pend;
  int       m_run [4];
  bit       m_chg, m_locked, m_pvld;

  direction_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .l(l), .r(r), .u(u), .d(d), .tick(tick),
    .direction(direction), .dir_change(dir_change)
  );

  always #5 clk = ~clk;

  function automatic bit [3:0] opposite(bit [3:0] h);
    case (h)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit legal_m(bit [3:0] req, bit [3:0] cur);
    return req != 0 && req != cur && req != opposite(cur);
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_prev = 0; m_dir = 0; m_pend = 0;
    m_chg = 0; m_locked = 0; m_pvld = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_update(bit [3:0] btn, bit tk);
    bit [3:0] press, req;
    press = m_lvl & ~m_lvl_prev;
    req = 0;
    for (int i = 0; i < 4; i++) if (press[i] && req == 0) req = 4'(1 << i);
    m_chg = 0;
    if (!m_locked) begin
      if (legal_m(req, m_dir)) begin m_dir = req; m_chg = 1; m_locked = 1; end
    end else begin
      if (req != 0) begin m_pend = req; m_pvld = 1; end
      if (tk) begin
        if (m_pvld && legal_m(m_pend, m_dir)) begin m_dir = m_pend; m_chg = 1; end
        else m_locked = 0;
        m_pvld = 0; m_pend = 0;
      end
    end
    m_lvl_prev = m_lvl;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic check(string tag, logic [4:0] obs, logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {chg,dir}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(bit [3:0] btn, bit tk);
    {d, u, r, l} = btn;
    tick = tk;
    model_update(btn, tk);
    @(posedge clk); #1;
    if (dir_change === 1'b1) pulses++;
    check("model", {dir_change, direction}, {m_chg, m_dir});
  endtask

  task automatic hold(bit [3:0] btn, int n);
    for (int k = 0; k < n; k++) step(btn, 1'b0);
  endtask

  task automatic assert_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_reset", {dir_change, direction}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit [3:0] cur;
    logic [4:0] exp;
    reset = 1'b0; l = 0; r = 0; u = 0; d = 0; tick = 0;
    model_reset();
    #1 check("reset_state", {dir_change, direction}, 5'b0);
    @(negedge clk);
    reset = 1'b1;

    // bounce on r never survives debounce
    foreach (cur[i]) ;
    step(4'b0010, 0); step(4'b0010, 0); step(4'b0010, 0); step(4'b0000, 0);
    step(4'b0010, 0); step(4'b0000, 0); step(4'b0010, 0); step(4'b0000, 0);
    hold(4'b0000, 8);
    check("bounce_no_press", {dir_change, direction}, 5'b0);

    // r held: pulse exactly on edge 7
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      step(4'b0010, 0);
      exp = (k >= 7) ? {(k == 7), 4'b0010} : 5'b0;
      check("r_latency", {dir_change, direction}, exp);
    end
    check("r_single_pulse", 5'(pulses), 5'd1);
    step(4'b0010, 1);
    hold(4'b0000, 8);

    // opposite refused in OPEN, perpendicular accepted
    pulses = 0;
    hold(4'b0001, 9); hold(4'b0000, 8);
    check("left_refused", {dir_change, direction}, 5'b0_0010);
    check("left_no_pulse", 5'(pulses), 5'd0);
    hold(4'b0100, 9);
    check("up_accepted", {dir_change, direction}, 5'b0_0100);
    check("up_pulse", 5'(pulses), 5'd1);

    // LOCKED: r then d pending, d is opposite -> dropped at tick, FSM opens
    pulses = 0;
    hold(4'b0000, 8); hold(4'b0010, 9); hold(4'b0000, 8); hold(4'b1000, 9); hold(4'b0000, 2);
    step(4'b0000, 1);
    check("pending_dropped", {dir_change, direction}, 5'b0_0100);
    check("locked_no_pulse", 5'(pulses), 5'd0);
    hold(4'b0001, 9);
    check("open_after_drop", {dir_change, direction}, 5'b0_0001);

    // simultaneous l and u: l wins; u later accepted
    assert_reset();
    hold(4'b0101, 9);
    check("priority_l", {dir_change, direction}, 5'b0_0001);
    step(4'b0101, 1);
    hold(4'b0000, 8); hold(4'b0100, 9);
    check("u_after_tick", {dir_change, direction}, 5'b0_0100);

    // reset mid-debounce with pending valid while LOCKED
    hold(4'b0000, 8); hold(4'b0010, 9); hold(4'b0000, 8); hold(4'b1000, 3);
    assert_reset();
    pulses = 0;
    hold(4'b0000, 20);
    check("post_reset_quiet", {dir_change, direction}, 5'b0);
    check("post_reset_no_pulse", 5'(pulses), 5'd0);

    // button held across reset is a fresh press
    hold(4'b0010, 3);
    assert_reset();
    hold(4'b0010, 9);
    check("held_through_reset", {dir_change, direction}, 5'b0_0010);

    // random buttons and ticks
    cur = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
      step(cur, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/direction_conditioner.md
DIRECTION_CONDITIONER -- requirements
Module: direction_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 The module SHALL have parameter CNT_W, default 20, meaning the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 l, r, u, d  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 tick  input  1  one-cycle game-update pulse in the clk domain, marking a snake move.
REQ-007 direction  output  4  registered one-hot heading: 0001 left, 0010 right, 0100 up, 1000 down, 0000 stopped.
REQ-008 dir_change  output  1  registered one-cycle pulse in the same cycle direction takes a new value.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each button SHALL have an independent debounced level and CNT_W-bit counter.
- counter clears whenever the synced sample equals the debounced level
- otherwise counter increments
- debounced level toggles and counter clears on the cycle the counter reaches DEBOUNCE_CYCLES-1
REQ-011 A press event SHALL be a 0->1 transition of a debounced level; a release SHALL generate no event.
REQ-012 Simultaneous press events SHALL be resolved by fixed priority l > r > u > d, and only the winner is considered.
REQ-013 A request SHALL be legal when all of the following hold:
- it differs from the current direction
- it is not the opposite of the current direction (left/right, up/down)
- any request is legal when the direction is 0000, except one that equals 0000
REQ-014 The lock FSM SHALL have two states, OPEN and LOCKED.
REQ-015 In OPEN, a legal request SHALL update direction at the next edge, assert dir_change for that cycle, and move the FSM to LOCKED.
REQ-016 In OPEN, an illegal request SHALL be discarded with no output change.
REQ-017 In LOCKED, any request SHALL be written into a one-deep pending register (one-hot plus valid bit), and a later request SHALL overwrite an earlier one.
REQ-018 On tick in LOCKED with pending valid, the pending request SHALL be checked against the current direction:
- if legal, it is applied with a dir_change pulse, the FSM stays LOCKED, and pending clears
- if illegal, it is discarded, pending clears, and the FSM goes to OPEN
REQ-019 On tick in LOCKED with no pending request, the FSM SHALL go to OPEN.
REQ-020 A request arriving in the same cycle as tick while LOCKED SHALL overwrite pending and be evaluated by that tick.
REQ-021 tick in OPEN SHALL have no effect.
REQ-022 Latency in OPEN SHALL be DEBOUNCE_CYCLES+3 clk edges, counted from the first edge that samples a raw button high (2 synchronizer + DEBOUNCE_CYCLES debounce + 1 update), provided the button stays high throughout.
REQ-023 Holding a button SHALL produce exactly one press event, and direction SHALL hold until a later legal request is accepted.

Reset
REQ-024 On reset low, the following SHALL apply asynchronously, regardless of in-progress debounce or lock state:
- direction = 0000
- dir_change = 0
- FSM = OPEN
- pending cleared
- all synchronizers, debounced levels and counters = 0
REQ-025 After reset deasserts, a button already held high SHALL be accepted as a fresh press once debounced.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-026 Reset, then r held high -> direction=0010 and a single dir_change pulse exactly 7 edges after r is first sampled.
REQ-027 r pulsed high for 3 cycles, with bounce low/high/low/high at cycle intervals -> no press event, direction stays 0000.
REQ-028 direction=0010 in OPEN, l pressed -> no change, no pulse; then u pressed -> 0100 with a pulse, FSM LOCKED.
REQ-029 direction=0100 LOCKED, r then d pressed before tick -> pending holds d (opposite of up); on tick it is discarded, direction stays 0100, no pulse, FSM OPEN.
REQ-030 l and u debounce high in the same cycle from 0000 -> direction=0001; after tick, releasing and re-pressing u -> 0100.
REQ-031 reset asserted mid-debounce with pending valid and FSM LOCKED -> all outputs 0 immediately; with no press after release, no dir_change occurs.
